// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - serializes LC-3b fetch and data requests onto one memory port.
// Optional MEM_ARB_JOINT_RESP_EN releases both resps of a round together in RESP.
module mem_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_read,
   input  logic [15:0] inst_addr,
   output logic        inst_resp,
   output logic [15:0] inst_rdata,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [1:0]  mem_byte_enable,
   input  logic [15:0] mem_addr,
   input  logic [15:0] mem_wdata,
   output logic        mem_resp,
   output logic [15:0] mem_rdata,
   output logic        pmem_read,
   output logic        pmem_write,
   output logic [15:0] pmem_address,
   output logic [15:0] pmem_wdata,
   output logic [1:0]  pmem_byte_enable,
   input  logic        pmem_resp,
   input  logic [15:0] pmem_rdata
);

   typedef enum logic [1:0] {IDLE, SERVE_D, SERVE_I, RESP} state_t;

   state_t      state;
   logic        want_d;
   logic        want_i;
   logic [15:0] i_addr_q;
`ifdef MEM_ARB_JOINT_RESP_EN
   logic        d_done;
`endif

   assign want_d = mem_read | mem_write;

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         want_i           <= 1'b0;
         i_addr_q         <= 16'h0;
         inst_resp        <= 1'b0;
         inst_rdata       <= 16'h0;
         mem_resp         <= 1'b0;
         mem_rdata        <= 16'h0;
         pmem_read        <= 1'b0;
         pmem_write       <= 1'b0;
         pmem_address     <= 16'h0;
         pmem_wdata       <= 16'h0;
         pmem_byte_enable <= 2'b00;
`ifdef MEM_ARB_JOINT_RESP_EN
         d_done           <= 1'b0;
`endif
      end else begin
         inst_resp <= 1'b0;
         mem_resp  <= 1'b0;
         case (state)
            IDLE: begin
               want_i   <= inst_read;
               i_addr_q <= inst_addr;
               // Data wins: it belongs to the older instruction in the pipeline.
               if (want_d) begin
                  state            <= SERVE_D;
                  pmem_address     <= mem_addr;
                  pmem_wdata       <= mem_wdata;
                  pmem_byte_enable <= mem_byte_enable;
                  pmem_write       <= mem_write;
                  pmem_read        <= ~mem_write;
               end else if (inst_read) begin
                  state            <= SERVE_I;
                  pmem_address     <= inst_addr;
                  pmem_wdata       <= 16'h0;
                  pmem_byte_enable <= 2'b00;
                  pmem_read        <= 1'b1;
               end
            end
            SERVE_D: begin
               if (pmem_resp) begin
                  mem_rdata  <= pmem_write ? 16'h0 : pmem_rdata;
                  pmem_read  <= 1'b0;
                  pmem_write <= 1'b0;
`ifdef MEM_ARB_JOINT_RESP_EN
                  d_done     <= 1'b1;
`endif
                  if (want_i) begin
                     state            <= SERVE_I;
                     pmem_read        <= 1'b1;
                     pmem_address     <= i_addr_q;
                     pmem_wdata       <= 16'h0;
                     pmem_byte_enable <= 2'b00;
`ifndef MEM_ARB_JOINT_RESP_EN
                     mem_resp         <= 1'b1;
`endif
                  end else begin
                     state    <= RESP;
                     mem_resp <= 1'b1;
                  end
               end
            end
            SERVE_I: begin
               if (pmem_resp) begin
                  inst_rdata <= pmem_rdata;
                  pmem_read  <= 1'b0;
                  inst_resp  <= 1'b1;
`ifdef MEM_ARB_JOINT_RESP_EN
                  mem_resp   <= d_done;
`endif
                  state      <= RESP;
               end
            end
            RESP: begin
               want_i <= 1'b0;
`ifdef MEM_ARB_JOINT_RESP_EN
               d_done <= 1'b0;
`endif
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed-vector bench for mem_arbiter.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_read;
   logic [15:0] inst_addr;
   logic        inst_resp;
   logic [15:0] inst_rdata;
   logic        mem_read;
   logic        mem_write;
   logic [1:0]  mem_byte_enable;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_resp;
   logic [15:0] mem_rdata;
   logic        pmem_read;
   logic        pmem_write;
   logic [15:0] pmem_address;
   logic [15:0] pmem_wdata;
   logic [1:0]  pmem_byte_enable;
   logic        pmem_resp;
   logic [15:0] pmem_rdata;

   mem_arbiter dut (
      .clk(clk), .rst(rst),
      .inst_read(inst_read), .inst_addr(inst_addr), .inst_resp(inst_resp), .inst_rdata(inst_rdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
      .pmem_wdata(pmem_wdata), .pmem_byte_enable(pmem_byte_enable),
      .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;
   int lat;
   int cnt;
   logic prev_resp;
   logic prev_strobe;

   logic        rd  [0:15];
   logic        wr  [0:15];
   logic [15:0] adr [0:15];
   logic [15:0] wd  [0:15];
   logic [1:0]  be  [0:15];
   logic        ir  [0:15];
   logic        mr  [0:15];
   logic [15:0] ird [0:15];
   logic [15:0] mrd [0:15];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] mem_table(input logic [15:0] a);
      case (a)
         16'h0040: mem_table = 16'h1234;
         16'h0080: mem_table = 16'h9999;
         16'h3000: mem_table = 16'hAAAA;
         16'h0100: mem_table = 16'h5555;
         default:  mem_table = 16'hDEAD;
      endcase
   endfunction

   // Advance into cycle c, record DUT outputs, then play the memory for this cycle.
   task automatic step(input int c);
      logic strobe;
      @(posedge clk);
      #1;
      rd[c] = pmem_read;   wr[c] = pmem_write; adr[c] = pmem_address;
      wd[c] = pmem_wdata;  be[c] = pmem_byte_enable;
      ir[c] = inst_resp;   mr[c] = mem_resp;
      ird[c] = inst_rdata; mrd[c] = mem_rdata;
      strobe = pmem_read | pmem_write;
      if (!strobe) cnt = 0;
      else if (prev_resp || !prev_strobe) cnt = 1;
      else cnt++;
      pmem_resp   = strobe && (cnt == lat);
      pmem_rdata  = pmem_resp ? mem_table(pmem_address) : 16'h0;
      prev_resp   = pmem_resp;
      prev_strobe = strobe;
   endtask

   task automatic clear_req();
      inst_read = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
   endtask

   task automatic begin_test(input int l);
      lat = l; cnt = 0; prev_resp = 1'b0; prev_strobe = 1'b0;
   endtask

   initial begin
      int s;
      rst = 1'b1; clear_req();
      inst_addr = 16'h0; mem_addr = 16'h0; mem_wdata = 16'h0; mem_byte_enable = 2'b00;
      pmem_resp = 1'b0; pmem_rdata = 16'h0;
      begin_test(1);
      repeat (2) @(posedge clk);
      #1;
      check("rst_pmem_read", pmem_read, 0);
      check("rst_pmem_write", pmem_write, 0);
      check("rst_pmem_addr", pmem_address, 0);
      check("rst_pmem_wdata_be", {pmem_wdata, pmem_byte_enable}, 0);
      check("rst_resps", {inst_resp, mem_resp}, 0);
      check("rst_rdata", {inst_rdata, mem_rdata}, 0);
      rst = 1'b0;

      // Fetch only, 3-cycle memory
      begin_test(3);
      inst_read = 1'b1; inst_addr = 16'h0040;
      s = 0;
      for (int c = 1; c <= 8; c++) begin
         step(c);
         if (c == 1) clear_req();
         s += int'(mr[c]);
      end
      check("fetch_rd1", rd[1], 1);
      check("fetch_rd3", rd[3], 1);
      check("fetch_rd4", rd[4], 0);
      check("fetch_addr", adr[1], 16'h0040);
      check("fetch_iresp3", ir[3], 0);
      check("fetch_iresp4", ir[4], 1);
      check("fetch_iresp5", ir[5], 0);
      check("fetch_irdata", ird[4], 16'h1234);
      check("fetch_no_mresp", s, 0);

      // Store, 2-cycle memory
      begin_test(2);
      mem_write = 1'b1; mem_addr = 16'h2000; mem_wdata = 16'hBEEF; mem_byte_enable = 2'b01;
      s = 0;
      for (int c = 1; c <= 8; c++) begin
         step(c);
         if (c == 1) clear_req();
         s += int'(ir[c]);
      end
      check("store_wr1", wr[1], 1);
      check("store_wr2", wr[2], 1);
      check("store_wr3", wr[3], 0);
      check("store_rd1", rd[1], 0);
      check("store_addr", adr[2], 16'h2000);
      check("store_wdata", wd[2], 16'hBEEF);
      check("store_be", be[2], 2'b01);
      check("store_mresp2", mr[2], 0);
      check("store_mresp3", mr[3], 1);
      check("store_mresp4", mr[4], 0);
      check("store_no_iresp", s, 0);

      // Simultaneous load and fetch, 2-cycle memory each
      begin_test(2);
      mem_read = 1'b1; mem_addr = 16'h3000; inst_read = 1'b1; inst_addr = 16'h0100;
      for (int c = 1; c <= 8; c++) begin
         step(c);
         if (c == 1) clear_req();
      end
      for (int c = 1; c <= 8; c++) check("dual_no_overlap", rd[c] & wr[c], 0);
      check("dual_rd2", rd[2], 1);
      check("dual_rd4", rd[4], 1);
      check("dual_rd5", rd[5], 0);
      check("dual_daddr", adr[2], 16'h3000);
      check("dual_iaddr", adr[3], 16'h0100);
      check("dual_iresp4", ir[4], 0);
      check("dual_iresp5", ir[5], 1);
      check("dual_iresp6", ir[6], 0);
      check("dual_irdata", ird[5], 16'h5555);
      check("dual_mrdata", mrd[5], 16'hAAAA);
`ifdef MEM_ARB_JOINT_RESP_EN
      check("dual_mresp3", mr[3], 0);
      check("dual_mresp5", mr[5], 1);
`else
      check("dual_mresp3", mr[3], 1);
      check("dual_mresp4", mr[4], 0);
      check("dual_mresp5", mr[5], 0);
`endif
      check("dual_mresp6", mr[6], 0);

      // Read and write together is a write; load data reads back as zero
      begin_test(2);
      mem_read = 1'b1; mem_write = 1'b1; mem_addr = 16'h2000; mem_wdata = 16'h1111;
      mem_byte_enable = 2'b11;
      for (int c = 1; c <= 8; c++) begin
         step(c);
         if (c == 1) clear_req();
      end
      check("rw_wr1", wr[1], 1);
      check("rw_rd1", rd[1], 0);
      check("rw_mresp3", mr[3], 1);
      check("rw_mrdata", mrd[3], 16'h0);

      // Fetch address changes while the fetch is in flight
      begin_test(3);
      inst_read = 1'b1; inst_addr = 16'h0040;
      step(1);
      step(2);
      inst_addr = 16'h0080;
      step(3);
      inst_read = 1'b0;
      for (int c = 4; c <= 8; c++) step(c);
      check("chg_addr3", adr[3], 16'h0040);
      check("chg_iresp4", ir[4], 1);
      check("chg_irdata", ird[4], 16'h1234);
      check("chg_rd5", rd[5], 0);

      // Reset while a load is in flight
      begin_test(5);
      mem_read = 1'b1; mem_addr = 16'h3000;
      step(1);
      clear_req();
      step(2);
      check("abort_rd2", rd[2], 1);
      rst = 1'b1;
      step(3);
      rst = 1'b0;
      check("abort_rd3", rd[3], 0);
      check("abort_addr3", adr[3], 16'h0);
      check("abort_rdata3", {ird[3], mrd[3]}, 0);
      s = 0;
      for (int c = 4; c <= 12; c++) begin
         step(c);
         s += int'(mr[c]) + int'(ir[c]) + int'(rd[c]) + int'(wr[c]);
      end
      check("abort_quiet", s, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
